// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
// The optional signed-overflow output is enabled by SERIAL_SUB_OVF_EN (see serial_sub).
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub.sv
// One-bit full-subtractor cell: diff = a - b - bin, borrow out in bout.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor diff = a - b - bin, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_diff;
    logic cell_bout;

    full_sub u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Next-state logic: operand capture, per-bit shift, and result publication.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                br_d   = cell_bout;
                res_d  = {cell_diff, res_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    // Last bit: the cell is looking at the operand MSBs right now.
                    diff_d  = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_sr_q[0] ^ b_sr_q[0]) & (a_sr_q[0] ^ cell_diff);
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed table, corner sequences, random ops vs. model.
module tb_serial_sub;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] last_diff = '0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Drive an op so that the next rising edge accepts it; returns edges from accept to done (-1 on timeout).
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input string nm, output int lat);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        lat = -1;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            chk({nm, "_hold"}, 32'(diff), 32'(last_diff));
        end
    endtask

    task automatic check_result(input string nm, input int lat, input logic [7:0] ed,
                                input logic eb, input logic eo);
        chk({nm, "_lat"},  32'(lat),  32'(WIDTH));
        chk({nm, "_diff"}, 32'(diff), 32'(ed));
        chk({nm, "_bout"}, 32'(bout), 32'(eb));
        chk({nm, "_idle"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"},  32'(ovf),  32'(eo));
`else
        if (eo === 1'bx) $display("unexpected unknown ovf expectation");
`endif
        last_diff = ed;
    endtask

    // Higher-level reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output logic [7:0] ed, output logic eb, output logic eo);
        int u;
        int s;
        logic [31:0] uv;
        u  = int'(ia) - int'(ib) - int'(ibin);
        uv = u;
        ed = uv[7:0];
        eb = (u < 0);
        s  = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        eo = (s > 127) || (s < -128);
    endtask

    vec_t vecs[6];
    int   lat;
    int   pulses;
    logic [7:0] ed;
    logic       eb;
    logic       eo;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i), lat);
            check_result($sformatf("vec%0d", i), lat, vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pulse", i), 32'(done), 32'd0);
        end

        // Back-to-back: second start issued in the done cycle.
        @(negedge clk);
        run_op(8'h00, 8'h00, 1'b1, "b2b_a", lat);
        check_result("b2b_a", lat, 8'hFF, 1'b1, 1'b0);
        run_op(8'hAA, 8'h55, 1'b0, "b2b_b", lat);
        check_result("b2b_b", lat, 8'h55, 1'b0, 1'b1);

        // Start re-pulsed during SHIFT must be ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        lat = -1;
        for (int k = 1; k <= WIDTH + 6; k++) begin
            if (k == 3) begin
                a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    chk("ign_diff", 32'(diff), 32'hDE);
                    chk("ign_bout", 32'(bout), 32'd1);
                end
            end
        end
        chk("ign_lat", 32'(lat), 32'(WIDTH));
        chk("ign_pulses", 32'(pulses), 32'd1);
        last_diff = 8'hDE;

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_diff", 32'(diff), 32'd0);
        chk("mrst_bout", 32'(bout), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("mrst_nodone", 32'(pulses), 32'd0);
        last_diff = 8'h00;
        @(negedge clk);
        run_op(8'h10, 8'h01, 1'b0, "post_rst", lat);
        check_result("post_rst", lat, 8'h0F, 1'b0, 1'b0);

        // Random operations against the arithmetic model, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rbin;
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            if (($urandom % 2) == 0) @(negedge clk);
            model(ra, rb, rbin, ed, eb, eo);
            run_op(ra, rb, rbin, $sformatf("rnd%0d", i), lat);
            check_result($sformatf("rnd%0d", i), lat, ed, eb, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
